// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// Iterative shift-add multiply and restoring divide on a 2W+1 bit accumulator.
// Optional build macro MULDIV_FAST_MULT_EN: multiply computes the full product
// in one step during FIX instead of iterating; divide is unaffected.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; HI/LO valid; MTHI/MTLO written directly
// RUN   | one iteration per cycle while the counter runs down to 1
// FIX   | apply latched signs, commit HI/LO, pulse done
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             unsign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH:0]   acc;
  logic [WIDTH-1:0]   dsr;
  logic               is_div;
  logic               skip;
  logic               div_zero;
  logic               neg_lo;
  logic               neg_hi;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               short_path;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_next;
  logic [2*WIDTH:0]   div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH:0]   div_next;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign a_mag = (!unsign && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag = (!unsign && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign stall = hilo_read & busy;

  // Operations that bypass iteration: divide by zero, and multiply in the fast build.
  always_comb begin
    short_path = op && (b == '0);
`ifdef MULDIV_FAST_MULT_EN
    short_path = short_path || !op;
`endif
  end

  // One iteration of each algorithm; the extra top accumulator bit holds the trial-subtract borrow.
  always_comb begin
    mul_sum   = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, dsr} : '0);
    mul_next  = {1'b0, mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:0], 1'b0};
    div_diff  = div_shift[2*WIDTH:WIDTH] - {1'b0, dsr};
    div_next  = div_diff[WIDTH] ? div_shift : {div_diff, div_shift[WIDTH-1:1], 1'b1};
  end

  // Sign fix-up of the magnitude results for the FIX commit.
  always_comb begin
`ifdef MULDIV_FAST_MULT_EN
    prod_mag = (2*WIDTH)'(dsr) * (2*WIDTH)'(acc[WIDTH-1:0]);
`else
    prod_mag = acc[2*WIDTH-1:0];
`endif
    prod = neg_lo ? (~prod_mag + 1'b1) : prod_mag;
    quo  = neg_lo ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem  = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  // Sequencer: reset, then MTHI/MTLO (abort), then normal state progression.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      dsr      <= '0;
      is_div   <= 1'b0;
      skip     <= 1'b0;
      div_zero <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (mthi || mtlo) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_div   <= op;
            dsr      <= op ? b_mag : a_mag;
            acc      <= (op && b == '0) ? {{(WIDTH+1){1'b0}}, a}
                                        : {{(WIDTH+1){1'b0}}, (op ? a_mag : b_mag)};
            div_zero <= op && (b == '0);
            neg_lo   <= !unsign && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi   <= !unsign && a[WIDTH-1];
            skip     <= short_path;
            cnt      <= short_path ? CNT_W'(1) : CNT_W'(WIDTH);
            state    <= RUN;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          if (!skip) acc <= is_div ? div_next : mul_next;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= FIX;
            done  <= 1'b1;
          end
        end
        FIX: begin
          if (is_div) begin
            hi <= div_zero ? acc[WIDTH-1:0] : rem;
            lo <= div_zero ? '1 : quo;
          end else begin
            hi <= prod[2*WIDTH-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for MULT/MULTU/DIV/DIVU; owns the architectural HI/LO registers.
- Sits beside the main ALU in the execute stage. Takes operands at issue, iterates a shift-add multiply or restoring divide, then commits the result to HI/LO.
- Raises a stall when the pipeline reads HI/LO (MFHI/MFLO) while an operation is still in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; launches an operation with the current a, b, op, unsign
- op  input  1  0 = multiply, 1 = divide
- unsign  input  1  1 = unsigned (MULTU/DIVU), 0 = signed
- a  input  WIDTH  rs operand (dividend / multiplicand)
- b  input  WIDTH  rt operand (divisor / multiplier)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- hilo_read  input  1  pipeline is executing MFHI or MFLO this cycle
- hi  output  WIDTH  HI register (remainder, or upper product)
- lo  output  WIDTH  LO register (quotient, or lower product)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse in the cycle HI/LO are committed
- stall  output  1  equals hilo_read AND busy, combinational

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0; counter and internal accumulators cleared. Reset mid-operation abandons the operation with no commit.
- States:
  - IDLE: on start, latch magnitudes of a and b, using two's-complement absolute value when unsign=0. Also latch the result signs: product sign = a[W-1]^b[W-1]; quotient sign likewise; remainder sign = a[W-1]. Load counter = WIDTH and go to RUN. busy rises the cycle after start.
  - RUN: one iteration per cycle and the counter decrements.
    - Multiply: if multiplier LSB is set, add multiplicand to the upper accumulator half; shift the 2W accumulator right by 1.
    - Divide: shift the remainder:quotient pair left by 1; trial-subtract the divisor; if the result is non-negative, keep it and set the quotient LSB.
    - When the counter reaches 1 on an iteration, go to FIX next.
  - FIX: negate results as required by the latched signs, write hi/lo, pulse done, go to IDLE. busy falls in the same cycle done is asserted.
- Latency: start at cycle T gives done at T+WIDTH+1 (33 for WIDTH=32); hi/lo show the new values from T+WIDTH+2.
- Divide by zero (b==0): skip RUN. FIX is entered next cycle with hi=a and lo=all-ones, regardless of unsign. done at T+2.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of the magnitude path; no special case.
- start while busy: ignored, no restart. start and reset in the same cycle: reset wins.
- mthi/mtlo while IDLE: register written next edge.
- mthi/mtlo while busy: operation aborted to IDLE with no commit and no done; the written register takes wdata; the other register is unchanged.
- mthi/mtlo and start in the same IDLE cycle: the write lands; start is ignored.
- mthi and mtlo together: both written with wdata.
- hilo_read while IDLE: stall=0; hi/lo are valid.
- FIX cycle: busy=1, so stall=1 if hilo_read is asserted; the read succeeds on the following cycle.
- Arithmetic: the accumulator is 2W+1 bits internally so the divide trial-subtract needs no extra sign logic.

Optional Feature:
- Macro MULDIV_FAST_MULT_EN.
- Defined: multiply skips RUN. The full 2W product is computed combinationally from the latched magnitudes in FIX, so done arrives at T+2; divide is unchanged.
- Undefined: multiply is iterative with WIDTH+1 latency as above.
- All hazard, abort and reset rules are identical in both builds.

Test Plan:
- Unsigned mult: start, op=0, unsign=1, a=0xFFFFFFFF, b=0x2. Expect done at T+33, hi=0x00000001, lo=0xFFFFFFFE; with MULDIV_FAST_MULT_EN, done at T+2.
- Signed div: op=1, unsign=0, a=-7 (0xFFFFFFF9), b=2. Expect lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- Divide by zero: a=0x1234, b=0. Expect done at T+2, hi=0x00001234, lo=0xFFFFFFFF.
- Hazard: hilo_read=1 held from T+5. Expect stall=1 through the FIX cycle, stall=0 the cycle after done.
- Abort: mtlo=1 with wdata=0xAA at T+10 of a multiply. Expect lo=0xAA, hi equal to its prior value, no done, busy=0 next cycle.
- Reset mid-op: reset at T+12. Expect hi=lo=0, busy=0; a new start runs a clean 33-cycle operation.
